// File: rtl/crc_define.sv
// Shared CRC definitions: mode and FSM encodings, per-mode width/byte-count/polynomial lookup, bit-reversal helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package crc_define;

    // CRC mode selection as presented on mode_i
    typedef enum logic [1:0] {
        MODE_CRC8        = 2'd0,  // poly 0x07
        MODE_CRC16_CCITT = 2'd1,  // poly 0x1021
        MODE_CRC16_IBM   = 2'd2,  // poly 0x8005
        MODE_CRC32       = 2'd3   // poly 0x04C11DB7
    } crc_mode_t;

    // Frame checker FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] BYTE_CNT_MAX = 3'd7;

    // Number of trailing CRC bytes carried by a frame
    function automatic logic [2:0] crc_nbytes(input crc_mode_t m);
        logic [2:0] n;
        case (m)
            MODE_CRC8:  n = 3'd1;
            MODE_CRC32: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

    // Mask selecting the low W bits of a 32-bit container
    function automatic logic [31:0] crc_mask(input crc_mode_t m);
        logic [31:0] k;
        case (m)
            MODE_CRC8:  k = 32'h0000_00FF;
            MODE_CRC32: k = 32'hFFFF_FFFF;
            default:    k = 32'h0000_FFFF;
        endcase
        return k;
    endfunction

    // Generator polynomial, right-aligned, implicit top bit omitted
    function automatic logic [31:0] crc_poly(input crc_mode_t m);
        logic [31:0] p;
        case (m)
            MODE_CRC8:        p = 32'h0000_0007;
            MODE_CRC16_CCITT: p = 32'h0000_1021;
            MODE_CRC16_IBM:   p = 32'h0000_8005;
            default:          p = 32'h04C1_1DB7;
        endcase
        return p;
    endfunction

    // Left shift that aligns a W-bit CRC to bit 31 (32 - W)
    function automatic logic [4:0] crc_align(input crc_mode_t m);
        logic [4:0] s;
        case (m)
            MODE_CRC8:  s = 5'd24;
            MODE_CRC32: s = 5'd0;
            default:    s = 5'd16;
        endcase
        return s;
    endfunction

    // Reverse the bit order of a byte
    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Reverse the bit order of the low W bits; upper bits come out zero
    function automatic logic [31:0] bitrev_w(input crc_mode_t m, input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        case (m)
            MODE_CRC8: begin
                for (int i = 0; i < 8; i++) begin
                    r[i] = v[7-i];
                end
            end
            MODE_CRC32: begin
                for (int i = 0; i < 32; i++) begin
                    r[i] = v[31-i];
                end
            end
            default: begin
                for (int i = 0; i < 16; i++) begin
                    r[i] = v[15-i];
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of MSB-first CRC division for any of the four supported polynomials.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module crc_byte_step
    import crc_define::*;
(
    input  logic [7:0]  data_i,
    input  logic [31:0] crc_i,
    input  crc_mode_t   mode_i,
    output logic [31:0] crc_o
);

    logic [4:0]  sh;
    logic [31:0] poly_al;
    logic [31:0] acc;

    // Work left-aligned at bit 31 so one datapath serves every width,
    // then shift back down, which zero-extends the W-bit result.
    always_comb begin
        sh      = crc_align(mode_i);
        poly_al = crc_poly(mode_i) << sh;
        acc     = (crc_i << sh) ^ {data_i, 24'd0};
        for (int i = 0; i < 8; i++) begin
            if (acc[31]) begin
                acc = (acc << 1) ^ poly_al;
            end else begin
                acc = acc << 1;
            end
        end
        crc_o = acc >> sh;
    end

endmodule

// File: rtl/crc_check.sv
// Streams a frame (payload + trailing CRC, MSB first), recomputes its CRC and flags pass / short-frame error.
// Latency: last byte accepted at cycle T -> done_o at T+2, next byte accepted at T+3.
// Backpressure: ready_o high in IDLE/RECV, low while the result is evaluated. Macro CRC_CHECK_CNT_EN adds pass/fail counters.
module crc_check
    import crc_define::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  mode_i,
    input  logic [31:0] init_i,
    input  logic [31:0] xorv_i,
    input  logic        revin_i,
    input  logic        revout_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        err_o,
    output logic [31:0] crc_o
`ifdef CRC_CHECK_CNT_EN
    ,
    output logic [15:0] pass_cnt_o,
    output logic [15:0] fail_cnt_o
`endif
);

    state_t      state;
    crc_mode_t   mode_lat;
    logic [31:0] xorv_lat;
    logic        revin_lat;
    logic        revout_lat;
    logic [31:0] shift_buf;
    logic [2:0]  fill;
    logic [2:0]  byte_cnt;
    logic [31:0] crc_reg;

    logic        accept;
    logic [2:0]  n_lat;
    logic        feed;
    logic [7:0]  oldest;
    logic [7:0]  step_in;
    logic [31:0] step_out;
    logic [31:0] computed;
    logic [31:0] received;
    logic        short_frame;
    logic        match;

    assign accept = valid_i && ready_o;
    assign n_lat  = crc_nbytes(mode_lat);
    assign feed   = accept && (state == ST_RECV) && (fill == n_lat);

    // Pick the oldest byte still inside the N-byte window and optionally reflect it
    always_comb begin
        oldest = shift_buf[15:8];
        case (mode_lat)
            MODE_CRC8:  oldest = shift_buf[7:0];
            MODE_CRC32: oldest = shift_buf[31:24];
            default:    oldest = shift_buf[15:8];
        endcase
        step_in = revin_lat ? bitrev8(oldest) : oldest;
    end

    crc_byte_step u_step (
        .data_i (step_in),
        .crc_i  (crc_reg),
        .mode_i (mode_lat),
        .crc_o  (step_out)
    );

    // Final CRC and comparison against the bytes left in the window
    always_comb begin
        computed    = (revout_lat ? bitrev_w(mode_lat, crc_reg) : crc_reg)
                      ^ (xorv_lat & crc_mask(mode_lat));
        received    = shift_buf & crc_mask(mode_lat);
        short_frame = (byte_cnt <= n_lat);
        match       = (computed == received);
    end

    // Frame FSM with registered handshake and result outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            mode_lat   <= MODE_CRC8;
            xorv_lat   <= '0;
            revin_lat  <= 1'b0;
            revout_lat <= 1'b0;
            shift_buf  <= '0;
            fill       <= '0;
            byte_cnt   <= '0;
            crc_reg    <= '0;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_o      <= 1'b0;
            crc_o      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // Configuration is frozen for the whole frame here
                        mode_lat   <= crc_mode_t'(mode_i);
                        xorv_lat   <= xorv_i;
                        revin_lat  <= revin_i;
                        revout_lat <= revout_i;
                        crc_reg    <= init_i & crc_mask(crc_mode_t'(mode_i));
                        shift_buf  <= {24'd0, data_i};
                        fill       <= 3'd1;
                        byte_cnt   <= 3'd1;
                        if (last_i) begin
                            state   <= ST_CHECK;
                            ready_o <= 1'b0;
                        end else begin
                            state   <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        // The byte falling out of the N-byte window is payload
                        if (feed) begin
                            crc_reg <= step_out;
                        end
                        shift_buf <= {shift_buf[23:0], data_i};
                        if (fill != n_lat) begin
                            fill <= fill + 3'd1;
                        end
                        if (byte_cnt != BYTE_CNT_MAX) begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                        if (last_i) begin
                            state   <= ST_CHECK;
                            ready_o <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    pass_o <= match && !short_frame;
                    err_o  <= short_frame;
                    crc_o  <= computed;
                    done_o <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_o <= 1'b1;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRC_CHECK_CNT_EN
    // Saturating frame statistics; short frames count as failures
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass_cnt_o <= '0;
            fail_cnt_o <= '0;
        end else if (state == ST_CHECK) begin
            if (match && !short_frame) begin
                if (pass_cnt_o != 16'hFFFF) begin
                    pass_cnt_o <= pass_cnt_o + 16'd1;
                end
            end else begin
                if (fail_cnt_o != 16'hFFFF) begin
                    fail_cnt_o <= fail_cnt_o + 16'd1;
                end
            end
        end
    end
`endif

endmodule
